// File: rtl/sdram_ctrl_if_param.sv
// -----------------------------------------------------------------------------
// sdram_ctrl_if_param
//
// Control interface between the 4-port arbiter and the SDRAM command FSM.
// Registers the host command/address, runs the power-up initialisation
// sequence (wait, precharge, N auto-refreshes, load-mode), generates periodic
// refresh ticks and tracks owed refreshes in a saturating pending counter.
// A REINIT pulse (accepted only once init has completed) restarts everything.
//
// Ports
//   CLK, RESET_N            clock, asynchronous active-low reset
//   CMD[1:0], ADDR          host command (00 NOP, 01 READA, 10 WRITEA) / address
//   REF_ACK                 command FSM issued one refresh (1-cycle pulse)
//   CM_ACK                  command FSM accepted a command
//   REINIT                  request full re-initialisation (1-cycle pulse)
//   NOP, READA, WRITEA      registered one-hot command decode
//   REFRESH, PRECHARGE,
//   LOAD_MODE               init-sequence command pulses
//   SADDR                   ADDR delayed one cycle
//   INIT_REQ, INIT_DONE     power-up wait active / init sequence complete
//   REF_REQ, REF_URGENT,
//   REF_PEND[2:0], REF_OVF  refresh bookkeeping
//   CMD_ACK                 acknowledge pulse to the host
// -----------------------------------------------------------------------------
module sdram_ctrl_if_param #(
  parameter int ASIZE        = 23,
  parameter int INIT_PER     = 24000,
  parameter int INIT_GAP     = 20,
  parameter int INIT_REF_NUM = 8,
  parameter int REF_PER      = 1024,
  parameter int REF_MAX_PEND = 4
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [1:0]       CMD,
  input  logic [ASIZE-1:0] ADDR,
  input  logic             REF_ACK,
  input  logic             CM_ACK,
  input  logic             REINIT,
  output logic             NOP,
  output logic             READA,
  output logic             WRITEA,
  output logic             REFRESH,
  output logic             PRECHARGE,
  output logic             LOAD_MODE,
  output logic [ASIZE-1:0] SADDR,
  output logic             INIT_REQ,
  output logic             INIT_DONE,
  output logic             REF_REQ,
  output logic             REF_URGENT,
  output logic [2:0]       REF_PEND,
  output logic             REF_OVF,
  output logic             CMD_ACK
);

  // Init sequence milestones on the 24-bit init counter.
  localparam logic [23:0] INIT_PER_C = 24'(INIT_PER);
  localparam logic [23:0] PRE_AT_C   = 24'(INIT_PER + INIT_GAP);
  localparam logic [23:0] LMR_AT_C   = 24'(INIT_PER + (INIT_REF_NUM + 2) * INIT_GAP);
  localparam logic [23:0] END_AT_C   = 24'(INIT_PER + (INIT_REF_NUM + 3) * INIT_GAP);
  localparam logic [15:0] REF_PER_C  = 16'(REF_PER);
  localparam logic [2:0]  REF_MAX_C  = 3'(REF_MAX_PEND);

  logic [ASIZE-1:0] saddr_q, saddr_d;
  logic             nop_q, nop_d;
  logic             reada_q, reada_d;
  logic             writea_q, writea_d;
  logic             refresh_q, refresh_d;
  logic             precharge_q, precharge_d;
  logic             load_mode_q, load_mode_d;
  logic             init_req_q, init_req_d;
  logic             init_done_q, init_done_d;
  logic [23:0]      init_cnt_q, init_cnt_d;
  logic [15:0]      ref_timer_q, ref_timer_d;
  logic [2:0]       pend_q, pend_d;
  logic             ref_ovf_q, ref_ovf_d;
  logic             cmd_ack_q, cmd_ack_d;

  logic             reinit_acc_s;
  logic             ref_tick_s;
  logic             ref_ack_s;
  logic             ref_hit_s;

  // REINIT is only honoured once the init sequence has completed.
  assign reinit_acc_s = REINIT & init_done_q;
  // Refresh acks are meaningless until init is done.
  assign ref_ack_s    = REF_ACK & init_done_q;

  // Init sequencer: counter, done flag and the init command pulses.
  always_comb begin
    ref_hit_s = 1'b0;
    for (int k = 1; k <= INIT_REF_NUM; k++) begin
      if (init_cnt_q == 24'(INIT_PER + (k + 1) * INIT_GAP)) begin
        ref_hit_s = 1'b1;
      end else begin
        ref_hit_s = ref_hit_s;
      end
    end

    if (reinit_acc_s) begin
      init_cnt_d  = 24'd0;
      init_done_d = 1'b0;
      // The restarted sequence shows INIT_REQ straight away.
      init_req_d  = 1'b1;
      precharge_d = 1'b0;
      refresh_d   = 1'b0;
      load_mode_d = 1'b0;
    end else begin
      if (init_cnt_q == END_AT_C) begin
        init_cnt_d  = init_cnt_q;
        init_done_d = 1'b1;
      end else begin
        init_cnt_d  = init_cnt_q + 24'd1;
        init_done_d = init_done_q;
      end
      init_req_d  = (init_cnt_q < INIT_PER_C);
      precharge_d = (init_cnt_q == PRE_AT_C);
      refresh_d   = ref_hit_s;
      load_mode_d = (init_cnt_q == LMR_AT_C);
    end
  end

  // Host command decode, address register and host acknowledge.
  always_comb begin
    saddr_d   = ADDR;
    cmd_ack_d = CM_ACK & ~cmd_ack_q;
    if (!init_done_q) begin
      nop_d    = 1'b1;
      reada_d  = 1'b0;
      writea_d = 1'b0;
    end else begin
      case (CMD)
        2'b00: begin nop_d = 1'b1; reada_d = 1'b0; writea_d = 1'b0; end
        2'b01: begin nop_d = 1'b0; reada_d = 1'b1; writea_d = 1'b0; end
        2'b10: begin nop_d = 1'b0; reada_d = 1'b0; writea_d = 1'b1; end
        default: begin nop_d = 1'b0; reada_d = 1'b0; writea_d = 1'b0; end
      endcase
    end
  end

  // Refresh interval timer; ticks REF_PER+1 cycles apart once init is done.
  always_comb begin
    ref_tick_s = 1'b0;
    if (reinit_acc_s || !init_done_q) begin
      ref_timer_d = REF_PER_C;
    end else if (ref_timer_q == 16'd0) begin
      ref_tick_s  = 1'b1;
      ref_timer_d = REF_PER_C;
    end else begin
      ref_timer_d = ref_timer_q - 16'd1;
    end
  end

  // Pending refresh counter with saturation and sticky overflow.
  always_comb begin
    pend_d    = pend_q;
    ref_ovf_d = ref_ovf_q;
    if (reinit_acc_s) begin
      pend_d    = 3'd0;
      ref_ovf_d = 1'b0;
    end else begin
      case ({ref_tick_s, ref_ack_s})
        2'b10: begin
          if (pend_q == REF_MAX_C) begin
            ref_ovf_d = 1'b1;
          end else begin
            pend_d = pend_q + 3'd1;
          end
        end
        2'b01: begin
          if (pend_q != 3'd0) begin
            pend_d = pend_q - 3'd1;
          end else begin
            pend_d = pend_q;
          end
        end
        // Simultaneous tick and ack cancel, including at the maximum.
        default: begin
          pend_d = pend_q;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      saddr_q     <= '0;
      nop_q       <= 1'b0;
      reada_q     <= 1'b0;
      writea_q    <= 1'b0;
      refresh_q   <= 1'b0;
      precharge_q <= 1'b0;
      load_mode_q <= 1'b0;
      init_req_q  <= 1'b0;
      init_done_q <= 1'b0;
      init_cnt_q  <= 24'd0;
      ref_timer_q <= REF_PER_C;
      pend_q      <= 3'd0;
      ref_ovf_q   <= 1'b0;
      cmd_ack_q   <= 1'b0;
    end else begin
      saddr_q     <= saddr_d;
      nop_q       <= nop_d;
      reada_q     <= reada_d;
      writea_q    <= writea_d;
      refresh_q   <= refresh_d;
      precharge_q <= precharge_d;
      load_mode_q <= load_mode_d;
      init_req_q  <= init_req_d;
      init_done_q <= init_done_d;
      init_cnt_q  <= init_cnt_d;
      ref_timer_q <= ref_timer_d;
      pend_q      <= pend_d;
      ref_ovf_q   <= ref_ovf_d;
      cmd_ack_q   <= cmd_ack_d;
    end
  end

  assign NOP        = nop_q;
  assign READA      = reada_q;
  assign WRITEA     = writea_q;
  assign REFRESH    = refresh_q;
  assign PRECHARGE  = precharge_q;
  assign LOAD_MODE  = load_mode_q;
  assign SADDR      = saddr_q;
  assign INIT_REQ   = init_req_q;
  assign INIT_DONE  = init_done_q;
  assign REF_OVF    = ref_ovf_q;
  assign CMD_ACK    = cmd_ack_q;
  // Refresh status is hidden until the init sequence has finished.
  assign REF_PEND   = init_done_q ? pend_q : 3'd0;
  assign REF_REQ    = init_done_q & (pend_q != 3'd0);
  assign REF_URGENT = init_done_q & (pend_q == REF_MAX_C);

endmodule

// File: tb/tb_sdram_ctrl_if_param.sv
// -----------------------------------------------------------------------------
// Directed testbench for sdram_ctrl_if_param using the small test parameter
// set INIT_PER=100, INIT_GAP=10, INIT_REF_NUM=2, REF_PER=50, REF_MAX_PEND=3.
// -----------------------------------------------------------------------------
module tb_sdram_ctrl_if_param;

  localparam int ASIZE = 23;

  logic             clk;
  logic             rst_n;
  logic [1:0]       cmd;
  logic [ASIZE-1:0] addr;
  logic             ref_ack;
  logic             cm_ack;
  logic             reinit;
  logic             nop, reada, writea, refresh, precharge, load_mode;
  logic [ASIZE-1:0] saddr;
  logic             init_req, init_done, ref_req, ref_urgent, ref_ovf, cmd_ack;
  logic [2:0]       ref_pend;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int d1    = 0;
  int d2    = 0;

  sdram_ctrl_if_param #(
    .ASIZE(ASIZE), .INIT_PER(100), .INIT_GAP(10), .INIT_REF_NUM(2),
    .REF_PER(50), .REF_MAX_PEND(3)
  ) dut (
    .CLK(clk), .RESET_N(rst_n), .CMD(cmd), .ADDR(addr), .REF_ACK(ref_ack),
    .CM_ACK(cm_ack), .REINIT(reinit), .NOP(nop), .READA(reada), .WRITEA(writea),
    .REFRESH(refresh), .PRECHARGE(precharge), .LOAD_MODE(load_mode),
    .SADDR(saddr), .INIT_REQ(init_req), .INIT_DONE(init_done),
    .REF_REQ(ref_req), .REF_URGENT(ref_urgent), .REF_PEND(ref_pend),
    .REF_OVF(ref_ovf), .CMD_ACK(cmd_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic test_reset();
    logic [37:0] obs;
    obs = {nop, reada, writea, refresh, precharge, load_mode, saddr, init_req,
           init_done, ref_req, ref_urgent, ref_pend, ref_ovf, cmd_ack};
    n_cmp++;
    if (obs !== 38'd0) begin
      n_bad++;
      $display("FAIL reset_state got=%h exp=0", obs);
    end
  endtask

  // Walk one full init sequence (edges with init_cnt = 0..150), optionally
  // pulsing REINIT and REF_ACK at given counter values; both must be ignored.
  task automatic init_walk(input int reinit_at, input int ack_at);
    logic [8:0] obs;
    logic [8:0] exp;
    int         hot;
    cmd = 2'b01;
    for (int c = 0; c <= 150; c++) begin
      reinit  = (c == reinit_at);
      ref_ack = (c == ack_at);
      tick();
      reinit  = 1'b0;
      ref_ack = 1'b0;
      // {INIT_REQ, PRECHARGE, REFRESH, LOAD_MODE, INIT_DONE, NOP, READA, WRITEA, REF_REQ}
      exp = {(c < 100), (c == 110), (c == 120 || c == 130), (c == 140),
             (c == 150), 1'b1, 1'b0, 1'b0, 1'b0};
      obs = {init_req, precharge, refresh, load_mode, init_done, nop, reada,
             writea, ref_req};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL init_seq cnt=%0d got=%b exp=%b", c, obs, exp);
      end
      hot = int'(init_req) + int'(precharge) + int'(refresh) + int'(load_mode);
      n_cmp++;
      if (hot > 1) begin
        n_bad++;
        $display("FAIL init_overlap cnt=%0d got=%0d active exp<=1", c, hot);
      end
    end
  endtask

  task automatic test_cmd_decode();
    logic [1:0]       cmds  [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
    logic [2:0]       exps  [4] = '{3'b010, 3'b001, 3'b000, 3'b100};
    logic [ASIZE-1:0] addrs [4] = '{23'h7FFFFF, 23'h000001, 23'h2AAAAA, 23'h155555};
    logic [ASIZE-1:0] prev;
    prev = addr;
    for (int i = 0; i < 4; i++) begin
      cmd  = cmds[i];
      addr = addrs[i];
      #1;
      n_cmp++;
      if (saddr !== prev) begin
        n_bad++;
        $display("FAIL saddr_lag i=%0d got=%h exp=%h", i, saddr, prev);
      end
      tick();
      n_cmp++;
      if ({nop, reada, writea} !== exps[i]) begin
        n_bad++;
        $display("FAIL cmd_decode i=%0d got=%b exp=%b", i, {nop, reada, writea}, exps[i]);
      end
      n_cmp++;
      if (saddr !== addrs[i]) begin
        n_bad++;
        $display("FAIL saddr i=%0d got=%h exp=%h", i, saddr, addrs[i]);
      end
      prev = addrs[i];
    end
    cmd = 2'b00;
  endtask

  // Checks {REF_REQ, REF_URGENT, REF_OVF, REF_PEND} against expectation.
  task automatic test_refresh_pending();
    int         offs [8] = '{50, 51, 101, 102, 152, 153, 203, 204};
    logic [5:0] exps [8] = '{6'b000_000, 6'b100_001, 6'b100_001, 6'b100_010,
                             6'b100_010, 6'b110_011, 6'b110_011, 6'b111_011};
    logic [5:0] ack_exp [3] = '{6'b101_010, 6'b101_001, 6'b001_000};
    for (int i = 0; i < 8; i++) begin
      run_to(d1 + offs[i]);
      n_cmp++;
      if ({ref_req, ref_urgent, ref_ovf, ref_pend} !== exps[i]) begin
        n_bad++;
        $display("FAIL ref_pend t=+%0d got=%b exp=%b", offs[i],
                 {ref_req, ref_urgent, ref_ovf, ref_pend}, exps[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      ref_ack = 1'b1;
      tick();
      ref_ack = 1'b0;
      n_cmp++;
      if ({ref_req, ref_urgent, ref_ovf, ref_pend} !== ack_exp[i]) begin
        n_bad++;
        $display("FAIL ref_ack_drain i=%0d got=%b exp=%b", i,
                 {ref_req, ref_urgent, ref_ovf, ref_pend}, ack_exp[i]);
      end
    end
    run_to(d1 + 306);
    n_cmp++;
    if ({ref_req, ref_urgent, ref_ovf, ref_pend} !== 6'b101_010) begin
      n_bad++;
      $display("FAIL ref_pre_reinit got=%b exp=101010",
               {ref_req, ref_urgent, ref_ovf, ref_pend});
    end
  endtask

  task automatic test_reinit();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    // {INIT_DONE, REF_PEND, REF_OVF, REF_REQ, INIT_REQ}
    n_cmp++;
    if ({init_done, ref_pend, ref_ovf, ref_req, init_req} !== 7'b0_000_001) begin
      n_bad++;
      $display("FAIL reinit_clear got=%b exp=0000001",
               {init_done, ref_pend, ref_ovf, ref_req, init_req});
    end
    init_walk(60, 30);
    d2 = cyc;
  endtask

  task automatic test_ack_coincident();
    run_to(d2 + 4);
    ref_ack = 1'b1;
    tick();
    ref_ack = 1'b0;
    n_cmp++;
    if ({ref_req, ref_pend} !== 4'b0_000) begin
      n_bad++;
      $display("FAIL ack_at_zero got=%b exp=0000", {ref_req, ref_pend});
    end
    run_to(d2 + 51);
    n_cmp++;
    if (ref_pend !== 3'd1) begin
      n_bad++;
      $display("FAIL no_underflow got=%0d exp=1", ref_pend);
    end
    run_to(d2 + 153);
    n_cmp++;
    if ({ref_urgent, ref_ovf, ref_pend} !== 5'b10_011) begin
      n_bad++;
      $display("FAIL pend_max got=%b exp=10011", {ref_urgent, ref_ovf, ref_pend});
    end
    run_to(d2 + 203);
    ref_ack = 1'b1;
    tick();
    ref_ack = 1'b0;
    n_cmp++;
    if ({ref_urgent, ref_ovf, ref_pend} !== 5'b10_011) begin
      n_bad++;
      $display("FAIL ack_tick_at_max got=%b exp=10011", {ref_urgent, ref_ovf, ref_pend});
    end
    run_to(d2 + 255);
    n_cmp++;
    if ({ref_urgent, ref_ovf, ref_pend} !== 5'b11_011) begin
      n_bad++;
      $display("FAIL tick_at_max_ovf got=%b exp=11011", {ref_urgent, ref_ovf, ref_pend});
    end
  endtask

  task automatic test_cmd_ack_and_reset();
    logic       pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [37:0] obs;
    cm_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (cmd_ack !== pat[i]) begin
        n_bad++;
        $display("FAIL cmd_ack i=%0d got=%b exp=%b", i, cmd_ack, pat[i]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {nop, reada, writea, refresh, precharge, load_mode, saddr, init_req,
           init_done, ref_req, ref_urgent, ref_pend, ref_ovf, cmd_ack};
    n_cmp++;
    if (obs !== 38'd0) begin
      n_bad++;
      $display("FAIL async_reset got=%h exp=0", obs);
    end
    cm_ack = 1'b0;
    #10;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    cmd     = 2'b00;
    addr    = '0;
    ref_ack = 1'b0;
    cm_ack  = 1'b0;
    reinit  = 1'b0;
    #22;
    test_reset();
    rst_n = 1'b1;
    cyc   = 0;
    init_walk(-1, -1);
    d1 = cyc;
    test_cmd_decode();
    test_refresh_pending();
    test_reinit();
    test_ack_coincident();
    test_cmd_ack_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_ctrl_if_param.md
Name: sdram_ctrl_if_param

Overview:
Parametrised SDRAM control interface placed between the 4-port arbiter and the SDRAM command FSM. It registers the host command and address, and sequences power-up initialisation with a configurable wait, refresh count and spacing. It tracks owed auto-refreshes in a saturating pending counter, which allows refresh postponement and urgency signalling. It also supports a software-triggered re-initialisation.

Parameters:
ASIZE, 23, width of the combined bank/row/column address.
INIT_PER, 24000, power-up wait in CLK cycles, during which INIT_REQ is held high.
INIT_GAP, 20, spacing in cycles between init commands; also the tMRD wait after LOAD_MODE.
INIT_REF_NUM, 8, number of auto-refreshes issued during init (allowed range 1..255).
REF_PER, 1024, refresh interval in cycles (allowed range 1..65535).
REF_MAX_PEND, 4, maximum number of postponed refreshes (allowed range 2..7).

Ports:
CLK  in  1  controller clock.
RESET_N  in  1  asynchronous, active-low reset.
CMD  in  2  host command: 00 NOP, 01 READA, 10 WRITEA, 11 reserved.
ADDR  in  ASIZE  host address.
REF_ACK  in  1  one-cycle pulse: the command FSM has issued one refresh.
CM_ACK  in  1  command-accepted indication from the command FSM.
REINIT  in  1  one-cycle pulse requesting a full re-initialisation.
NOP/READA/WRITEA  out  1 each  registered command decode.
REFRESH/PRECHARGE/LOAD_MODE  out  1 each  init command pulses.
SADDR  out  ASIZE  registered ADDR.
INIT_REQ  out  1  high during the power-up wait.
INIT_DONE  out  1  init sequence complete.
REF_REQ  out  1  high when the pending refresh count is non-zero.
REF_URGENT  out  1  high when pending == REF_MAX_PEND.
REF_PEND  out  3  current pending refresh count.
REF_OVF  out  1  sticky flag: a refresh tick occurred while already at maximum pending.
CMD_ACK  out  1  acknowledge pulse to the host.

Behaviour:
- Reset: all outputs 0; internal init_cnt = 0; refresh timer = REF_PER; pending count = 0.
- SADDR: ADDR delayed by one cycle.
- Command decode: registered one-hot, 1-cycle latency. CMD=11 drives all three outputs to 0.
- While INIT_DONE=0: NOP is forced to 1 and READA/WRITEA to 0, whatever CMD is.
- CMD_ACK: set next cycle when CM_ACK=1 and CMD_ACK=0, otherwise 0. A held CM_ACK therefore gives a toggling 1/0 pattern.
- Init sequencer:
  - init_cnt is 24 bits and counts up each cycle from 0. It freezes at E = INIT_PER + (INIT_REF_NUM+3)*INIT_GAP.
  - INIT_REQ = 1 in the cycle after each edge where init_cnt < INIT_PER.
  - PRECHARGE pulses for one cycle after init_cnt == INIT_PER + INIT_GAP.
  - REFRESH pulses after init_cnt == INIT_PER + (k+1)*INIT_GAP, for k = 1..INIT_REF_NUM.
  - LOAD_MODE pulses after init_cnt == INIT_PER + (INIT_REF_NUM+2)*INIT_GAP.
  - INIT_DONE rises after init_cnt == E and stays high.
  - At most one of INIT_REQ/PRECHARGE/REFRESH/LOAD_MODE is high in any cycle.
- REINIT:
  - When sampled with INIT_DONE=1: clears init_cnt, INIT_DONE, pending count, REF_OVF and the refresh timer (reloaded to REF_PER). The full sequence restarts, with INIT_REQ high in the next cycle.
  - When sampled with INIT_DONE=0: ignored.
- Refresh timer:
  - Runs only while INIT_DONE=1; otherwise held at REF_PER.
  - Decrements each cycle. At 0 it generates a tick and reloads REF_PER, so ticks are exactly REF_PER+1 cycles apart.
- Pending count:
  - Tick only: pending +1, saturating at REF_MAX_PEND. A tick while already at max sets REF_OVF and leaves pending unchanged.
  - REF_ACK only: pending −1 if non-zero; REF_ACK with pending = 0 is ignored.
  - Tick and REF_ACK together: pending is unchanged. Exception: at max, the tick is absorbed by the ack and REF_OVF is not set.
- Outputs derived from pending:
  - REF_REQ, REF_URGENT and REF_PEND are combinational from the registered pending count.
  - They are held at 0 while INIT_DONE=0.
  - A REF_ACK during init is ignored.
- REF_OVF is cleared only by reset or by an accepted REINIT.

Test Plan:
Use INIT_PER=100, INIT_GAP=10, INIT_REF_NUM=2, REF_PER=50, REF_MAX_PEND=3 for all scenarios.
1. Release reset, no stimulus -> INIT_REQ high for 100 cycles; PRECHARGE pulse after cnt 110; REFRESH pulses after cnt 120 and 130; LOAD_MODE pulse after cnt 140; INIT_DONE after cnt 150; no overlap between pulses.
2. CMD=01 during init, then CMD=01/10/11/00 after INIT_DONE -> NOP=1 during init; afterwards READA, WRITEA, all-zero, NOP, each 1 cycle after CMD; SADDR tracks ADDR with a 1-cycle lag.
3. No REF_ACK after INIT_DONE -> REF_PEND goes 1,2,3 at 51-cycle intervals; REF_URGENT rises at 3; REF_OVF sets on the 4th tick; three REF_ACK pulses then return REF_PEND to 0 while REF_OVF stays 1.
4. REF_ACK coincident with a tick at REF_PEND=3 -> REF_PEND stays 3 and REF_OVF stays 0. REF_ACK at REF_PEND=0 -> count stays 0, no underflow.
5. REINIT mid-operation with REF_PEND=2 and REF_OVF=1 -> INIT_DONE, REF_PEND and REF_OVF all 0 next cycle; the full scenario-1 sequence repeats; a REINIT pulsed during that re-init is ignored.
6. CM_ACK held high for 5 cycles -> CMD_ACK pattern 1,0,1,0,1. Assert RESET_N low mid-sequence -> all outputs 0 immediately (asynchronously).
